instr_prog_loader: RTL and testbench
====================================

Name: instr_prog_loader

Overview:
Reverse of the rv32i control decode path. Accepts symbolic instructions (instr_type, func_code, register indices, immediate), encodes them into 32-bit RV32I words and writes them sequentially into instruction memory over a ready/ack handshake. The core is held in reset while loading. Used as the boot-time and bench-time program loader in front of the single-cycle core.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction word.
DEPTH, 64, maximum number of words loaded; the count reaches DEPTH when memory is full.
ADDR_W, 32, width of imem_addr.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  symbolic instruction present
in_ready  output  1  loader can accept an instruction
instr_type  input  instr_type_t  R, I-alu, LOAD, STORE, BRANCH
func_code  input  func_code_t  add/sub/and/or/slt selector (R and I-alu only)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  13  signed immediate; I/S use [11:0]; BRANCH uses [12:0] with bit0 = 0
prog_end  input  1  pulse: no more instructions
imem_we  output  1  write request, held until ack
imem_addr  output  ADDR_W  byte address
imem_wdata  output  32  encoded word
imem_ack  input  1  memory accepted the write
imem_rdata  input  32  readback data (used only with the optional feature)
hold_cpu  output  1  keep core in reset
done  output  1  load complete
err  output  1  sticky: illegal instruction or readback mismatch
word_count  output  $clog2(DEPTH+1)  words written

Behaviour:
- Reset: state IDLE, in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, hold_cpu=1, done=0, err=0, word_count=0. Reset mid-write drops the write immediately.
- FSM: IDLE -> WRITE on in_valid&&in_ready with a legal encoding. WRITE -> IDLE on imem_ack when word_count+1<DEPTH. WRITE -> DONE on imem_ack when word_count+1==DEPTH. IDLE -> DONE on prog_end. DONE is terminal until rst.
- in_ready=1 only in IDLE. The encoded word is registered at accept; imem_we rises the next cycle (1-cycle latency) and imem_addr/wdata stay stable until ack.
- On ack: imem_addr+=4 and word_count+=1 in the same edge.
- Encoding: opcodes R=0110011, I=0010011, LOAD=0000011 (f3=010), STORE=0100011 (f3=010), BRANCH=1100011 (f3=000). func3: add/sub=000, slt=010, or=110, and=111. funct7=0100000 only for R sub.
- Immediate packing: S=imm[11:5]|imm[4:0]; B=imm[12],imm[10:5],imm[4:1],imm[11].
- Illegal: sub on I-type, BRANCH with imm[0]=1, unknown enum. Result: err<=1, the word is consumed but not written, and the state stays IDLE.
- prog_end during WRITE is ignored; a pulse must be re-issued in IDLE. prog_end and in_valid in the same IDLE cycle: the instruction is accepted and prog_end is ignored.
- DONE: done=1, hold_cpu=0, in_ready=0. A full memory reaches DONE without prog_end.

Optional Feature:
LOADER_READBACK_EN: after each ack, enter VERIFY for one cycle with imem_we=0, compare imem_rdata with the written word, set err on mismatch, then apply the normal IDLE/DONE transition. Without the macro, imem_rdata is ignored and WRITE transitions directly.

Decomposition:
- rv32i_pkg gains the opcode constants (OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH), funct3/funct7 constants and loader_state_t.
- A combinational sub-module instr_enc (inputs instr_type, func_code, rd, rs1, rs2, imm; outputs word, illegal) is natural. The loader holds the FSM and counters.

Test Plan:
- add x3,x1,x2 with immediate ack -> imem_wdata=0x002081B3 at addr 0x0, word_count=1.
- sub x5,x6,x7, then lw x4,8(x2) -> 0x407302B3 at 0x0, 0x00812203 at 0x4.
- sw x5,12(x2), then beq x1,x2,-4 with 3-cycle ack delay -> 0x00512623 and 0xFE208EE3; imem_we is held 3 cycles each and in_ready=0 throughout.
- addi x1,x0,5, then prog_end -> 0x00500093 written; done=1, hold_cpu=0, in_ready=0.
- beq with imm=13'h3 (odd) -> no write, err=1, word_count unchanged; a following legal instruction still loads.
- DEPTH=2: three instructions -> DONE after the second ack, third never accepted. rst asserted mid-WRITE -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/instr_prog_loader_pkg.sv
// Shared RV32I encoding constants and types for the symbolic program loader.
package instr_prog_loader_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        IT_R      = 3'd0,
        IT_I      = 3'd1,
        IT_LOAD   = 3'd2,
        IT_STORE  = 3'd3,
        IT_BRANCH = 3'd4
    } instr_type_t;

    typedef enum logic [2:0] {
        FC_ADD = 3'd0,
        FC_SUB = 3'd1,
        FC_AND = 3'd2,
        FC_OR  = 3'd3,
        FC_SLT = 3'd4
    } func_code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_prog_loader_enc.sv
// Combinational encoder: symbolic instruction fields to a 32-bit RV32I word,
// flagging combinations that have no legal encoding.
module instr_prog_loader_enc
    import instr_prog_loader_pkg::*;
(
    input  instr_type_t instr_type,
    input  func_code_t  func_code,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [2:0] f3;
    logic       fc_bad;

    always_comb begin
        f3     = F3_ADD;
        fc_bad = 1'b0;
        case (func_code)
            FC_ADD, FC_SUB: f3 = F3_ADD;
            FC_SLT:         f3 = F3_SLT;
            FC_OR:          f3 = F3_OR;
            FC_AND:         f3 = F3_AND;
            default:        fc_bad = 1'b1;
        endcase
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (instr_type)
            IT_R: begin
                word    = {(func_code == FC_SUB) ? F7_SUB : F7_BASE, rs2, rs1, f3, rd, OPC_R};
                illegal = fc_bad;
            end
            IT_I: begin
                word    = {imm[11:0], rs1, f3, rd, OPC_I};
                illegal = fc_bad || (func_code == FC_SUB);
            end
            IT_LOAD:  word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
            IT_STORE: word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            IT_BRANCH: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_prog_loader.sv
// Sequential program loader: encodes accepted instructions and writes them to imem.
// Optional LOADER_READBACK_EN adds a one-cycle VERIFY readback compare after each ack.
module instr_prog_loader
    import instr_prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  instr_type_t                  instr_type,
    input  func_code_t                   func_code,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [12:0]                  imm,
    input  logic                         prog_end,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_rdata,
    output logic                         hold_cpu,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    loader_state_t state, next_state;
    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          last_word;

    instr_prog_loader_enc u_enc (
        .instr_type (instr_type),
        .func_code  (func_code),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .word       (enc_word),
        .illegal    (enc_illegal)
    );

    assign last_word = (word_count == CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                // An instruction in the same cycle as prog_end wins; illegal ones are dropped.
                if (in_valid) begin
                    if (!enc_illegal) next_state = ST_WRITE;
                end else if (prog_end) begin
                    next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (imem_ack) begin
`ifdef LOADER_READBACK_EN
                    next_state = ST_VERIFY;
`else
                    next_state = last_word ? ST_DONE : ST_IDLE;
`endif
                end
            end
            ST_VERIFY: next_state = (word_count == CW'(DEPTH)) ? ST_DONE : ST_IDLE;
            ST_DONE:   next_state = ST_DONE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        imem_we  = (state == ST_WRITE);
        done     = (state == ST_DONE);
        hold_cpu = (state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (enc_illegal) err <= 1'b1;
                        else             imem_wdata <= enc_word;
                    end
                end
                ST_WRITE: begin
                    if (imem_ack) begin
                        imem_addr  <= imem_addr + ADDR_W'(4);
                        word_count <= word_count + CW'(1);
                    end
                end
`ifdef LOADER_READBACK_EN
                ST_VERIFY: begin
                    if (imem_rdata != imem_wdata) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef LOADER_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
`endif

endmodule

// File: tb/tb_instr_prog_loader.sv
// Directed self-checking bench for instr_prog_loader (default DEPTH plus a DEPTH=2 instance).
module tb_instr_prog_loader;
    import instr_prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    instr_type_t instr_type = IT_R;
    func_code_t  func_code = FC_ADD;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [12:0] imm = '0;
    logic        prog_end = 1'b0;
    logic        imem_ack = 1'b0;

    logic        in_ready, imem_we, hold_cpu, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  word_count;

    logic        b_in_ready, b_we, b_hold, b_done, b_err;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_count = '0;
    logic [31:0] exp_addr  = '0;

    always #5 clk = ~clk;

    instr_prog_loader #(.BASE_ADDR(32'h0), .DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .func_code(func_code), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .prog_end(prog_end), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ack(imem_ack), .imem_rdata(imem_wdata),
        .hold_cpu(hold_cpu), .done(done), .err(err), .word_count(word_count)
    );

    instr_prog_loader #(.BASE_ADDR(32'h0), .DEPTH(2), .ADDR_W(32)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr_type(instr_type), .func_code(func_code), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .prog_end(prog_end), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .imem_ack(imem_ack), .imem_rdata(b_wdata),
        .hold_cpu(b_hold), .done(b_done), .err(b_err), .word_count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we",    32'(imem_we), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold",  32'(hold_cpu), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; prog_end = 1'b0; imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        exp_count = '0;
        exp_addr  = '0;
    endtask

    task automatic drive(input instr_type_t t, input func_code_t f, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
        instr_type = t; func_code = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic send(input instr_type_t t, input func_code_t f, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im,
                        input logic pe, input int unsigned dly, input logic [31:0] w);
        check("accept_ready", 32'(in_ready), 32'd1);
        drive(t, f, d, s1, s2, im);
        prog_end = pe;
        @(posedge clk); #1;
        in_valid = 1'b0; prog_end = 1'b0;
        check("we_rise", 32'(imem_we), 32'd1);
        check("wdata",   imem_wdata, w);
        check("addr",    imem_addr, exp_addr);
        check("ready_busy", 32'(in_ready), 32'd0);
        for (int unsigned i = 0; i < dly; i++) begin
            prog_end = (i == 1);
            @(posedge clk); #1;
            prog_end = 1'b0;
            check("we_held",    32'(imem_we), 32'd1);
            check("ready_held", 32'(in_ready), 32'd0);
            check("wdata_held", imem_wdata, w);
        end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        exp_count = exp_count + 1;
        exp_addr  = exp_addr + 4;
        check("count",   32'(word_count), exp_count);
        check("addr_inc", imem_addr, exp_addr);
        check("we_drop", 32'(imem_we), 32'd0);
        check("not_done", 32'(done), 32'd0);
    endtask

    task automatic send_illegal(input instr_type_t t, input func_code_t f, input logic [12:0] im);
        drive(t, f, 5'd1, 5'd1, 5'd2, im);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ill_err",   32'(err), 32'd1);
        check("ill_we",    32'(imem_we), 32'd0);
        check("ill_count", 32'(word_count), exp_count);
        check("ill_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        send(IT_R,     FC_ADD, 5'd3, 5'd1, 5'd2, 13'd0,  1'b1, 0, 32'h002081B3);
        send(IT_R,     FC_SUB, 5'd5, 5'd6, 5'd7, 13'd0,  1'b0, 0, 32'h407302B3);
        send(IT_LOAD,  FC_ADD, 5'd4, 5'd2, 5'd0, 13'd8,  1'b0, 0, 32'h00812203);
        send(IT_STORE, FC_ADD, 5'd0, 5'd2, 5'd5, 13'd12, 1'b0, 3, 32'h00512623);
        send(IT_BRANCH, FC_ADD, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b0, 3, 32'hFE208EE3);

        check("err_clean", 32'(err), 32'd0);
        send_illegal(IT_BRANCH, FC_ADD, 13'h3);
        send_illegal(IT_I, FC_SUB, 13'd5);
        send_illegal(instr_type_t'(3'd7), FC_ADD, 13'd0);
        send(IT_I, FC_OR, 5'd9, 5'd8, 5'd0, 13'h0F0, 1'b0, 1, 32'h0F046493);
        send(IT_I, FC_ADD, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 0, 32'h00500093);

        prog_end = 1'b1;
        @(posedge clk); #1;
        prog_end = 1'b0;
        check("done",      32'(done), 32'd1);
        check("done_hold", 32'(hold_cpu), 32'd0);
        check("done_rdy",  32'(in_ready), 32'd0);
        drive(IT_R, FC_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("done_no_we",    32'(imem_we), 32'd0);
        check("done_count",    32'(word_count), exp_count);
        check("done_sticky",   32'(done), 32'd1);

        do_reset();
        send(IT_R, FC_AND, 5'd10, 5'd11, 5'd12, 13'd0, 1'b0, 0, 32'h00C5F533);
        check("b_count1", 32'(b_count), 32'd1);
        check("b_done1",  32'(b_done), 32'd0);
        check("b_rdy1",   32'(b_in_ready), 32'd1);
        send(IT_R, FC_SLT, 5'd10, 5'd11, 5'd12, 13'd0, 1'b0, 0, 32'h00C5A533);
        check("b_count2", 32'(b_count), 32'd2);
        check("b_done2",  32'(b_done), 32'd1);
        check("b_hold2",  32'(b_hold), 32'd0);
        check("b_rdy2",   32'(b_in_ready), 32'd0);
        send(IT_R, FC_OR, 5'd10, 5'd11, 5'd12, 13'd0, 1'b0, 0, 32'h00C5E533);
        check("b_count3", 32'(b_count), 32'd2);
        check("b_addr3",  b_addr, 32'h8);
        check("b_we3",    32'(b_we), 32'd0);

        drive(IT_R, FC_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_we", 32'(imem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
